// File: rtl/aurora_multilane_block_scheduler.sv
// rtl/aurora_multilane_block_scheduler.sv - per-cycle 4-lane block set selection with sync headers
//
// Chooses one block set per non-paused cycle: clock-compensation idle, UserK,
// user data or idle, and registers it together with the 2-bit sync headers.
//
// Ports:
//   Clk          single clock domain
//   Rst          synchronous reset, active-high
//   LaneReady    all lanes aligned and bonded
//   TxPause      gearbox stall; current block set is held
//   SendBlock    UserK request level, held until BlockSent
//   UserKToSend  UserK payload per lane, block type already in [63:56]
//   DataValid    user data available
//   DataWords    user data, one 64-bit word per lane
//   DataReady    combinational accept for user data
//   BlockSent    one-cycle pulse when a UserK set is emitted
//   TxHeader     sync header per lane (01 data, 10 control)
//   TxData       block payload per lane
module aurora_multilane_block_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       LaneReady,
  input  logic                       TxPause,
  input  logic                       SendBlock,
  input  logic [NUM_LANES-1:0][63:0] UserKToSend,
  input  logic                       DataValid,
  input  logic [NUM_LANES-1:0][63:0] DataWords,
  output logic                       DataReady,
  output logic                       BlockSent,
  output logic [NUM_LANES-1:0][1:0]  TxHeader,
  output logic [NUM_LANES-1:0][63:0] TxData
);

  localparam logic [63:0] IDLE     = 64'h7800_0000_0000_0000;
  localparam logic [63:0] NR_IDLE  = 64'h7820_0000_0000_0000;
  localparam logic [63:0] CC_IDLE  = 64'h7880_0000_0000_0000;
  localparam logic [1:0]  HDR_DATA = 2'b01;
  localparam logic [1:0]  HDR_CTRL = 2'b10;

  localparam int CNT_W = $clog2(CC_PERIOD + 1);
  localparam int LEN_W = $clog2(CC_LEN + 1);

  typedef enum logic [1:0] {
    NOT_READY,
    RUN,
    CC
  } state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cc_cnt, cc_cnt_nxt;
  logic [LEN_W-1:0]           cc_len_cnt, cc_len_nxt;
  logic [NUM_LANES-1:0][1:0]  hdr_nxt;
  logic [NUM_LANES-1:0][63:0] data_nxt;
  logic                       bs_nxt;
  logic                       userk_req;

  // BlockSent masks the request that upstream has not yet had a cycle to retire.
  assign userk_req = SendBlock & ~BlockSent;
  assign DataReady = ~Rst & LaneReady & ~TxPause & (state == RUN) & ~userk_req;

  always_comb begin
    state_nxt  = state;
    cc_cnt_nxt = cc_cnt;
    cc_len_nxt = cc_len_cnt;
    hdr_nxt    = TxHeader;
    data_nxt   = TxData;
    bs_nxt     = 1'b0;
    if (!LaneReady) begin
      // Loss of alignment overrides pause and any CC burst in progress.
      state_nxt  = NOT_READY;
      cc_cnt_nxt = '0;
      cc_len_nxt = '0;
      hdr_nxt    = {NUM_LANES{HDR_CTRL}};
      data_nxt   = {NUM_LANES{NR_IDLE}};
    end else if (!TxPause) begin
      unique case (state)
        NOT_READY: begin
          state_nxt = RUN;
          hdr_nxt   = {NUM_LANES{HDR_CTRL}};
          data_nxt  = {NUM_LANES{NR_IDLE}};
        end
        RUN: begin
          if (cc_cnt == CNT_W'(CC_PERIOD - 1)) begin
            cc_cnt_nxt = '0;
            state_nxt  = CC;
          end else begin
            cc_cnt_nxt = cc_cnt + 1'b1;
          end
          // The CC entry cycle still carries a RUN-priority block set.
          if (userk_req) begin
            hdr_nxt  = {NUM_LANES{HDR_CTRL}};
            data_nxt = UserKToSend;
            bs_nxt   = 1'b1;
          end else if (DataValid) begin
            // DataReady is necessarily high on this branch.
            hdr_nxt  = {NUM_LANES{HDR_DATA}};
            data_nxt = DataWords;
          end else begin
            hdr_nxt  = {NUM_LANES{HDR_CTRL}};
            data_nxt = {NUM_LANES{IDLE}};
          end
        end
        CC: begin
          hdr_nxt  = {NUM_LANES{HDR_CTRL}};
          data_nxt = {NUM_LANES{CC_IDLE}};
          if (cc_len_cnt == LEN_W'(CC_LEN - 1)) begin
            cc_len_nxt = '0;
            state_nxt  = RUN;
          end else begin
            cc_len_nxt = cc_len_cnt + 1'b1;
          end
        end
        default: state_nxt = NOT_READY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= NOT_READY;
      cc_cnt     <= '0;
      cc_len_cnt <= '0;
      TxHeader   <= {NUM_LANES{HDR_CTRL}};
      TxData     <= {NUM_LANES{NR_IDLE}};
      BlockSent  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cc_cnt     <= cc_cnt_nxt;
      cc_len_cnt <= cc_len_nxt;
      TxHeader   <= hdr_nxt;
      TxData     <= data_nxt;
      BlockSent  <= bs_nxt;
    end
  end

endmodule

// File: tb/tb_aurora_multilane_block_scheduler.sv
// tb/tb_aurora_multilane_block_scheduler.sv - self-checking bench for the block scheduler
module tb_aurora_multilane_block_scheduler;

  localparam int P = 16;
  localparam int L = 3;
  localparam logic [63:0] IDLE    = 64'h7800_0000_0000_0000;
  localparam logic [63:0] NR_IDLE = 64'h7820_0000_0000_0000;
  localparam logic [63:0] CC_IDLE = 64'h7880_0000_0000_0000;
  localparam int K_NR = 0, K_IDLE = 1, K_UK = 2, K_DATA = 3, K_CC = 4;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              LaneReady = 1'b0;
  logic              TxPause = 1'b0;
  logic              SendBlock = 1'b0;
  logic [3:0][63:0]  UserKToSend = '0;
  logic              DataValid = 1'b0;
  logic [3:0][63:0]  DataWords = '0;
  logic              DataReady;
  logic              BlockSent;
  logic [3:0][1:0]   TxHeader;
  logic [3:0][63:0]  TxData;

  aurora_multilane_block_scheduler #(
    .NUM_LANES(4),
    .CC_PERIOD(P),
    .CC_LEN(L)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .LaneReady(LaneReady),
    .TxPause(TxPause),
    .SendBlock(SendBlock),
    .UserKToSend(UserKToSend),
    .DataValid(DataValid),
    .DataWords(DataWords),
    .DataReady(DataReady),
    .BlockSent(BlockSent),
    .TxHeader(TxHeader),
    .TxData(TxData)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model: whether the link is up, RUN sets since the last burst,
  // CC sets still owed, and the expected registered outputs.
  bit              m_up;
  int              m_runs;
  int              m_cc_left;
  bit              m_bs;
  bit              m_took;
  logic [3:0][1:0]  m_hdr;
  logic [3:0][63:0] m_data;

  function automatic logic [3:0][63:0] rep(input logic [63:0] v);
    logic [3:0][63:0] r;
    for (int l = 0; l < 4; l++) r[l] = v;
    return r;
  endfunction

  function automatic logic [3:0][63:0] dw_pat(input int s);
    logic [3:0][63:0] r;
    for (int l = 0; l < 4; l++) r[l] = {16'hDA7A, 16'(l), 32'(s)};
    return r;
  endfunction

  function automatic logic [3:0][63:0] uk_pat(input int s);
    logic [3:0][63:0] r;
    for (int l = 0; l < 4; l++) r[l] = {8'hD2, 8'(l), 16'h0, 32'(s)};
    return r;
  endfunction

  function automatic logic [3:0][63:0] kind_data(input int k, input int src);
    case (k)
      K_IDLE:  return rep(IDLE);
      K_UK:    return uk_pat(src);
      K_DATA:  return dw_pat(src);
      K_CC:    return rep(CC_IDLE);
      default: return rep(NR_IDLE);
    endcase
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit want_uk;
    m_took = 1'b0;
    if (Rst || !LaneReady) begin
      m_up = 0; m_runs = 0; m_cc_left = 0; m_bs = 0;
      m_hdr = {4{2'b10}}; m_data = rep(NR_IDLE);
    end else if (TxPause) begin
      m_bs = 0;
    end else if (!m_up) begin
      m_up = 1; m_bs = 0;
      m_hdr = {4{2'b10}}; m_data = rep(NR_IDLE);
    end else if (m_cc_left > 0) begin
      m_cc_left--; m_bs = 0;
      m_hdr = {4{2'b10}}; m_data = rep(CC_IDLE);
    end else begin
      m_runs++;
      if (m_runs == P) begin
        m_runs = 0;
        m_cc_left = L;
      end
      want_uk = SendBlock && !m_bs;
      if (want_uk) begin
        m_hdr = {4{2'b10}}; m_data = UserKToSend; m_bs = 1;
      end else if (DataValid) begin
        m_hdr = {4{2'b01}}; m_data = DataWords; m_bs = 0; m_took = 1;
      end else begin
        m_hdr = {4{2'b10}}; m_data = rep(IDLE); m_bs = 0;
      end
    end
  endtask

  // One clock: drive on the falling edge, check DataReady before the rising
  // edge, then check the registered outputs just after it.
  task automatic step(input bit rst, input bit lr, input bit pause, input bit send,
                      input bit valid, input logic [3:0][63:0] uk, input logic [3:0][63:0] dw);
    bit exp_dr;
    @(negedge Clk);
    Rst = rst; LaneReady = lr; TxPause = pause; SendBlock = send; DataValid = valid;
    UserKToSend = uk; DataWords = dw;
    #1;
    exp_dr = !Rst && LaneReady && !TxPause && m_up && (m_cc_left == 0) && !(SendBlock && !m_bs);
    chk("DataReady", DataReady, exp_dr);
    @(posedge Clk);
    model_edge();
    #1;
    chk("TxHeader", TxHeader, m_hdr);
    chk("TxData", TxData, m_data);
    chk("BlockSent", BlockSent, m_bs);
  endtask

  typedef struct {
    bit rst, lr, pause, send, valid;
    int kind;
    int src;
    bit bs;
    bit dr;
  } vec_t;

  vec_t vecs[14];
  bit   dr_seen;

  initial begin
    int src_seq, next_out, bad, n_data, n_cc, data_before, pulses, cnt;
    bit seen_cc;

    m_up = 0; m_runs = 0; m_cc_left = 0; m_bs = 0; m_took = 0;
    m_hdr = {4{2'b10}}; m_data = rep(NR_IDLE);

    //           rst lr p  s  v  kind    src bs dr
    vecs[0]  = '{1, 1, 0, 0, 0, K_NR,   0,  0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, K_NR,   0,  0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, K_IDLE, 0,  0, 1};
    vecs[3]  = '{0, 1, 0, 0, 1, K_DATA, 3,  0, 1};
    vecs[4]  = '{0, 1, 0, 1, 1, K_UK,   4,  1, 0};
    vecs[5]  = '{0, 1, 0, 0, 1, K_DATA, 5,  0, 1};
    vecs[6]  = '{0, 1, 0, 1, 1, K_UK,   6,  1, 0};
    vecs[7]  = '{0, 1, 0, 1, 1, K_DATA, 7,  0, 1};
    vecs[8]  = '{0, 1, 0, 1, 1, K_UK,   8,  1, 0};
    vecs[9]  = '{0, 1, 1, 0, 1, K_UK,   8,  0, 0};
    vecs[10] = '{0, 1, 0, 0, 1, K_DATA, 10, 0, 1};
    vecs[11] = '{0, 0, 0, 1, 1, K_NR,   0,  0, 0};
    vecs[12] = '{0, 1, 0, 0, 1, K_NR,   0,  0, 0};
    vecs[13] = '{0, 1, 0, 0, 1, K_DATA, 13, 0, 1};

    // Directed table: reset, first RUN set, UserK/data interleave, pause, lane drop.
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      Rst = vecs[i].rst; LaneReady = vecs[i].lr; TxPause = vecs[i].pause;
      SendBlock = vecs[i].send; DataValid = vecs[i].valid;
      UserKToSend = uk_pat(i); DataWords = dw_pat(i);
      #1;
      dr_seen = DataReady;
      chk($sformatf("vec%0d_dr", i), dr_seen, vecs[i].dr);
      @(posedge Clk);
      model_edge();
      #1;
      chk($sformatf("vec%0d_hdr", i), TxHeader,
          (vecs[i].kind == K_DATA) ? {4{2'b01}} : {4{2'b10}});
      chk($sformatf("vec%0d_data", i), TxData, kind_data(vecs[i].kind, vecs[i].src));
      chk($sformatf("vec%0d_bs", i), BlockSent, vecs[i].bs);
    end

    // CC burst with continuous data: 16 data sets, 3 CC sets, data resumes in order.
    step(1, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    step(0, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    src_seq = 0; next_out = 0; bad = 0; n_data = 0; n_cc = 0; data_before = -1;
    for (int c = 0; c < 30; c++) begin
      step(0, 1, 0, 0, 1, uk_pat(c), dw_pat(src_seq));
      if (m_took) src_seq++;
      if (TxHeader[0] == 2'b01) begin
        if (TxData !== dw_pat(next_out)) bad++;
        next_out++;
        n_data++;
      end
      if (TxData[0] == CC_IDLE) begin
        if (data_before < 0) data_before = n_data;
        n_cc++;
      end
    end
    chk("cc_data_before", 32'(data_before), 32'(P));
    chk("cc_burst_len", 32'(n_cc), 32'(L));
    chk("cc_data_total", 32'(n_data), 32'(30 - L));
    chk("cc_data_order", 32'(bad), 32'd0);

    // Pause during UserK and during CC.
    step(1, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    step(0, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    pulses = 0; n_cc = 0;
    step(0, 1, 0, 1, 0, uk_pat(77), dw_pat(0));
    pulses += BlockSent;
    chk("pause_uk_sent", TxData, uk_pat(77));
    step(0, 1, 1, 1, 0, uk_pat(77), dw_pat(0));
    pulses += BlockSent;
    chk("pause_uk_hold", TxData, uk_pat(77));
    for (int c = 0; c < 40; c++) begin
      step(0, 1, c[0], 0, 0, uk_pat(0), dw_pat(0));
      pulses += BlockSent;
      if (!c[0] && TxData[0] == CC_IDLE) n_cc++;
    end
    chk("pause_bs_pulses", 32'(pulses), 32'd1);
    chk("pause_cc_sets", 32'(n_cc), 32'(L));

    // LaneReady drop mid-CC with a pending UserK.
    step(1, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    step(0, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    for (int c = 0; c < P; c++) step(0, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    step(0, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
    chk("drop_in_cc", TxData, rep(CC_IDLE));
    step(0, 0, 0, 1, 0, uk_pat(55), dw_pat(0));
    chk("drop_nr", TxData, rep(NR_IDLE));
    chk("drop_no_bs", BlockSent, 1'b0);
    step(0, 1, 0, 1, 0, uk_pat(55), dw_pat(0));
    chk("drop_wait", TxData, rep(NR_IDLE));
    step(0, 1, 0, 1, 0, uk_pat(55), dw_pat(0));
    chk("drop_uk", TxData, uk_pat(55));
    chk("drop_uk_bs", BlockSent, 1'b1);
    cnt = 0; seen_cc = 0;
    for (int c = 0; c < P + 4; c++) begin
      step(0, 1, 0, 0, 0, uk_pat(0), dw_pat(0));
      if (TxData[0] == CC_IDLE) seen_cc = 1;
      if (!seen_cc) cnt++;
    end
    chk("drop_cc_restart", 32'(cnt), 32'(P - 1));

    // Randomized traffic against the model.
    src_seq = 1000;
    for (int c = 0; c < 1500; c++) begin
      bit r_rst, r_lr, r_p, r_s, r_v;
      r_rst = ($urandom_range(0, 299) == 0);
      r_lr  = ($urandom_range(0, 39) != 0);
      r_p   = ($urandom_range(0, 9) == 0);
      r_s   = ($urandom_range(0, 3) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      step(r_rst, r_lr, r_p, r_s, r_v, uk_pat(int'($urandom_range(0, 65535))), dw_pat(src_seq));
      if (m_took) src_seq++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
